// File: rtl/wb_dest_pipe_if.sv
// D-stage request/response bundle for the write-back destination pipe:
// destination select, source operands with Tuse, and the stall/forward results.
interface wb_dest_pipe_if #(
  parameter int AW    = 5,
  parameter int DEPTH = 3,
  parameter int TW    = 2
) ();
  localparam int FW = $clog2(DEPTH + 1);

  logic [AW-1:0]       rt_d;
  logic [AW-1:0]       rd_d;
  logic [1:0]          dst_sel;
  logic [TW-1:0]       tnew_d;
  logic                flush_i;
  logic [AW-1:0]       rs_d;
  logic                rs_use;
  logic [TW-1:0]       tuse_rs;
  logic                rt_use;
  logic [TW-1:0]       tuse_rt;
  logic [AW-1:0]       dst_d;
  logic [DEPTH*AW-1:0] dst_pipe;
  logic [DEPTH*TW-1:0] tnew_pipe;
  logic                stall_o;
  logic [FW-1:0]       fwd_rs;
  logic [FW-1:0]       fwd_rt;

  modport master (
    output rt_d, rd_d, dst_sel, tnew_d, flush_i, rs_d, rs_use, tuse_rs, rt_use, tuse_rt,
    input  dst_d, dst_pipe, tnew_pipe, stall_o, fwd_rs, fwd_rt
  );

  modport slave (
    input  rt_d, rd_d, dst_sel, tnew_d, flush_i, rs_d, rs_use, tuse_rs, rt_use, tuse_rt,
    output dst_d, dst_pipe, tnew_pipe, stall_o, fwd_rs, fwd_rt
  );
endinterface

// File: rtl/wb_dest_pipe.sv
// Write-back destination select plus E/M/W destination/Tnew tracking, producing
// the D-stage load-use stall and per-operand forwarding selects.
module wb_dest_pipe #(
  parameter int AW        = 5,
  parameter int DEPTH     = 3,
  parameter int TW        = 2,
  parameter int LINK_ADDR = 31
) (
  input logic          clk,
  input logic          reset,
  wb_dest_pipe_if.slave pif
);
  localparam int FW = $clog2(DEPTH + 1);

  logic [AW-1:0] dst_r  [DEPTH];
  logic [TW-1:0] tnew_r [DEPTH];

  logic [AW-1:0] dst_s;
  logic [DEPTH-1:0] rs_m_s;
  logic [DEPTH-1:0] rt_m_s;
  logic          rs_hit_s;
  logic          rt_hit_s;
  logic [TW-1:0] rs_tnew_s;
  logic [TW-1:0] rt_tnew_s;
  logic [FW-1:0] rs_idx_s;
  logic [FW-1:0] rt_idx_s;
  logic          stall_s;
  logic [FW-1:0] fwd_rs_s;
  logic [FW-1:0] fwd_rt_s;

  // D-stage destination select; 0 doubles as "no write"
  always_comb begin
    dst_s = {AW{1'b0}};
    case (pif.dst_sel)
      2'b00:   dst_s = pif.rt_d;
      2'b01:   dst_s = pif.rd_d;
      2'b10:   dst_s = AW'(LINK_ADDR);
      2'b11:   dst_s = {AW{1'b0}};
      default: dst_s = {AW{1'b0}};
    endcase
  end

  // Per-stage match vectors; $0 and unused operands never match
  always_comb begin
    rs_m_s = {DEPTH{1'b0}};
    rt_m_s = {DEPTH{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      rs_m_s[k] = pif.rs_use && (pif.rs_d != {AW{1'b0}}) && (dst_r[k] == pif.rs_d);
      rt_m_s[k] = pif.rt_use && (pif.rt_d != {AW{1'b0}}) && (dst_r[k] == pif.rt_d);
    end
  end

  // Youngest match wins: scan oldest first so the lowest index overwrites
  always_comb begin
    rs_hit_s  = 1'b0;
    rt_hit_s  = 1'b0;
    rs_tnew_s = {TW{1'b0}};
    rt_tnew_s = {TW{1'b0}};
    rs_idx_s  = {FW{1'b0}};
    rt_idx_s  = {FW{1'b0}};
    for (int k = DEPTH - 1; k >= 0; k--) begin
      rs_hit_s  = rs_m_s[k] ? 1'b1      : rs_hit_s;
      rs_tnew_s = rs_m_s[k] ? tnew_r[k] : rs_tnew_s;
      rs_idx_s  = rs_m_s[k] ? FW'(k)    : rs_idx_s;
      rt_hit_s  = rt_m_s[k] ? 1'b1      : rt_hit_s;
      rt_tnew_s = rt_m_s[k] ? tnew_r[k] : rt_tnew_s;
      rt_idx_s  = rt_m_s[k] ? FW'(k)    : rt_idx_s;
    end
  end

  // Stall when the youngest producer is not ready by the consumer's Tuse
  always_comb begin
    stall_s  = (rs_hit_s && (rs_tnew_s > pif.tuse_rs)) ||
               (rt_hit_s && (rt_tnew_s > pif.tuse_rt));
    fwd_rs_s = (rs_hit_s && (rs_tnew_s == {TW{1'b0}})) ? (rs_idx_s + FW'(1)) : {FW{1'b0}};
    fwd_rt_s = (rt_hit_s && (rt_tnew_s == {TW{1'b0}})) ? (rt_idx_s + FW'(1)) : {FW{1'b0}};
  end

  // Pipe advance; stall or flush injects one bubble into E, later stages never freeze
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        dst_r[k]  <= {AW{1'b0}};
        tnew_r[k] <= {TW{1'b0}};
      end
    end else begin
      if (stall_s || pif.flush_i) begin
        dst_r[0]  <= {AW{1'b0}};
        tnew_r[0] <= {TW{1'b0}};
      end else begin
        dst_r[0]  <= dst_s;
        tnew_r[0] <= (dst_s == {AW{1'b0}}) ? {TW{1'b0}} : pif.tnew_d;
      end
      for (int k = 1; k < DEPTH; k++) begin
        dst_r[k]  <= dst_r[k-1];
        tnew_r[k] <= (tnew_r[k-1] == {TW{1'b0}}) ? {TW{1'b0}} : (tnew_r[k-1] - TW'(1));
      end
    end
  end

  // Flatten tracked state onto the observation buses
  always_comb begin
    pif.dst_pipe  = {(DEPTH*AW){1'b0}};
    pif.tnew_pipe = {(DEPTH*TW){1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      pif.dst_pipe[k*AW +: AW]  = dst_r[k];
      pif.tnew_pipe[k*TW +: TW] = tnew_r[k];
    end
  end

  assign pif.dst_d   = dst_s;
  assign pif.stall_o = stall_s;
  assign pif.fwd_rs  = fwd_rs_s;
  assign pif.fwd_rt  = fwd_rt_s;
endmodule

// File: tb/tb_wb_dest_pipe.sv
// Scoreboard bench for wb_dest_pipe: a reference model of in-flight producers
// predicts each cycle's outputs; a negedge monitor pops and compares.
module tb_wb_dest_pipe;
  localparam int AW = 5, DEPTH = 3, TW = 2, LINK = 31;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_dest_pipe_if #(.AW(AW), .DEPTH(DEPTH), .TW(TW)) pif ();

  wb_dest_pipe #(.AW(AW), .DEPTH(DEPTH), .TW(TW), .LINK_ADDR(LINK)) dut (
    .clk   (clk),
    .reset (reset),
    .pif   (pif.slave)
  );

  typedef struct {
    logic [4:0]  dst_d;
    logic [14:0] dpipe;
    logic [5:0]  tpipe;
    logic        stall;
    logic [1:0]  frs;
    logic [1:0]  frt;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Producers in flight: destination and the Tnew they were issued with (index = age)
  int mdst[DEPTH];
  int mtn[DEPTH];

  function automatic int ready_in(input int k);
    int t;
    t = mtn[k] - k;
    return (t < 0) ? 0 : t;
  endfunction

  function automatic void resolve(input int s, input logic use_b, input int tuse,
                                  output logic st, output int fwd);
    bit found = 1'b0;
    st = 1'b0;
    fwd = 0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!found && use_b && s != 0 && mdst[k] == s) begin
        found = 1'b1;
        st = (ready_in(k) > tuse);
        fwd = (ready_in(k) == 0) ? k + 1 : 0;
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, ex, $time);
    end
  endtask

  // Predict the current cycle, push it, then advance the model across the edge
  task automatic tick();
    exp_t e;
    logic s1, s2;
    int f1, f2, d;
    case (pif.dst_sel)
      2'b00:   d = int'(pif.rt_d);
      2'b01:   d = int'(pif.rd_d);
      2'b10:   d = LINK;
      default: d = 0;
    endcase
    resolve(int'(pif.rs_d), pif.rs_use, int'(pif.tuse_rs), s1, f1);
    resolve(int'(pif.rt_d), pif.rt_use, int'(pif.tuse_rt), s2, f2);
    e.dst_d = 5'(d);
    e.stall = s1 | s2;
    e.frs = 2'(f1);
    e.frt = 2'(f2);
    for (int k = 0; k < DEPTH; k++) begin
      e.dpipe[k*5 +: 5] = 5'(mdst[k]);
      e.tpipe[k*2 +: 2] = 2'(ready_in(k));
    end
    if (chk_en) sbq.push_back(e);
    @(posedge clk);
    #1;
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        mdst[k] = 0;
        mtn[k] = 0;
      end
    end else begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        mdst[k] = mdst[k-1];
        mtn[k] = mtn[k-1];
      end
      if (e.stall || pif.flush_i) begin
        mdst[0] = 0;
        mtn[0] = 0;
      end else begin
        mdst[0] = d;
        mtn[0] = (d == 0) ? 0 : int'(pif.tnew_d);
      end
    end
  endtask

  task automatic drv(input logic rst, input int sel, input int rt, input int rd, input int tn,
                     input logic fl, input int rs, input logic rsu, input int tur,
                     input logic rtu, input int tut);
    reset       = rst;
    pif.dst_sel = 2'(sel);
    pif.rt_d    = 5'(rt);
    pif.rd_d    = 5'(rd);
    pif.tnew_d  = 2'(tn);
    pif.flush_i = fl;
    pif.rs_d    = 5'(rs);
    pif.rs_use  = rsu;
    pif.tuse_rs = 2'(tur);
    pif.rt_use  = rtu;
    pif.tuse_rt = 2'(tut);
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1'b0, 3, 0, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic rnd(input logic rst);
    drv(rst, $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7),
        $urandom_range(0, 3), ($urandom_range(0, 7) == 0), $urandom_range(0, 7),
        1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
        $urandom_range(0, 3));
  endtask

  // Monitor: compare every presented cycle against the oldest prediction
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk("dst_d", 32'(pif.dst_d), 32'(e.dst_d));
      chk("dst_pipe", 32'(pif.dst_pipe), 32'(e.dpipe));
      chk("tnew_pipe", 32'(pif.tnew_pipe), 32'(e.tpipe));
      chk("stall_o", 32'(pif.stall_o), 32'(e.stall));
      chk("fwd_rs", 32'(pif.fwd_rs), 32'(e.frs));
      chk("fwd_rt", 32'(pif.fwd_rt), 32'(e.frt));
    end
  end

  initial begin
    for (int k = 0; k < DEPTH; k++) begin
      mdst[k] = 0;
      mtn[k] = 0;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    rnd(1'b1);
    chk_en = 1'b1;
    rnd(1'b1);
    idle(3);
    // destination select and Tnew countdown through the stages
    drv(1'b0, 0, 8, 9, 2, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    drv(1'b0, 1, 8, 9, 1, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    drv(1'b0, 2, 8, 9, 3, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    drv(1'b0, 3, 8, 9, 2, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    idle(3);
    // load-use: stall once, then wait, then forward from W
    drv(1'b0, 0, 8, 0, 2, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    drv(1'b0, 3, 0, 0, 0, 1'b0, 8, 1'b1, 1, 1'b0, 0);
    drv(1'b0, 3, 0, 0, 0, 1'b0, 8, 1'b1, 1, 1'b0, 0);
    drv(1'b0, 3, 0, 0, 0, 1'b0, 8, 1'b1, 1, 1'b0, 0);
    idle(3);
    // youngest-match priority
    drv(1'b0, 1, 0, 5, 1, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    drv(1'b0, 1, 0, 5, 1, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    drv(1'b0, 3, 0, 0, 0, 1'b0, 5, 1'b1, 1, 1'b0, 0);
    idle(3);
    drv(1'b0, 1, 0, 5, 1, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    drv(1'b0, 1, 0, 5, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    drv(1'b0, 3, 0, 0, 0, 1'b0, 5, 1'b1, 1, 1'b0, 0);
    idle(3);
    // $0 never matches; unused rt never matches
    drv(1'b0, 3, 0, 0, 0, 1'b0, 0, 1'b1, 0, 1'b1, 0);
    drv(1'b0, 0, 6, 0, 3, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    drv(1'b0, 3, 6, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    drv(1'b0, 3, 6, 0, 0, 1'b0, 0, 1'b0, 0, 1'b1, 0);
    idle(3);
    // flush during a stall inserts a single bubble
    drv(1'b0, 0, 8, 0, 3, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    drv(1'b0, 3, 0, 0, 0, 1'b1, 8, 1'b1, 0, 1'b0, 0);
    idle(3);
    // reset while stalling clears everything at that edge
    drv(1'b0, 0, 8, 0, 3, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    drv(1'b0, 3, 0, 0, 0, 1'b0, 8, 1'b1, 0, 1'b0, 0);
    drv(1'b1, 3, 0, 0, 0, 1'b0, 8, 1'b1, 0, 1'b0, 0);
    drv(1'b0, 3, 0, 0, 0, 1'b0, 8, 1'b1, 0, 1'b0, 0);
    // randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) rnd($urandom_range(0, 63) == 0);
    @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
